// File: rtl/zcd_capture_sequencer_pkg.sv
// Shared definitions for the zero-crossing capture path.
//   zcd_state_e    : capture sequencer FSM encoding
//   CFG_*          : config_reg field offsets shared with zero_crossing_detector
package zcd_capture_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } zcd_state_e;

  localparam int CFG_START_BIT = 0;
  localparam int CFG_ABORT_BIT = 1;
  localparam int CFG_SKIP_LSB  = 8;
  localparam int CFG_SKIP_W    = 8;

endpackage

// File: rtl/zcd_capture_sequencer_if.sv
// ADC stream bundle for the capture sequencer.
//   in_data_valid/in_data          : raw ADC samples into the sequencer
//   out_data_valid/out_data/out_last: framed capture burst out of the sequencer
// master = stream source / burst sink, slave = the sequencer itself.
interface zcd_capture_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              in_data_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_data_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_data_valid, in_data,
    input  out_data_valid, out_data, out_last
  );

  modport slave (
    input  in_data_valid, in_data,
    output out_data_valid, out_data, out_last
  );
endinterface

// File: rtl/zcd_capture_sequencer_period_meter.sv
// Sample-period meter: counts valid samples between consecutive crossings
// while the sequencer is armed and latches the count on each crossing.
//   clk, rst : clock, synchronous active-low reset
//   clr      : restart the sample counter (accepted start)
//   en       : sequencer is in ARMED
//   smp_vld  : ADC sample strobe
//   pulse    : crossing pulse
//   seen     : an earlier crossing was already seen in this ARMED episode
//   period   : samples between the last two crossings
module zcd_period_meter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             smp_vld,
  input  logic             pulse,
  input  logic             seen,
  output logic [CNT_W-1:0] period
);

  logic [CNT_W-1:0] smp_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_cnt <= '0;
      period  <= '0;
    end else if (clr) begin
      smp_cnt <= '0;
    end else if (en) begin
      if (pulse) begin
        if (seen) period <= smp_cnt;
        // a sample landing on the crossing opens the new period
        smp_cnt <= smp_vld ? CNT_W'(1) : '0;
      end else if (smp_vld) begin
        smp_cnt <= sat_inc(smp_cnt);
      end
    end
  end

endmodule

// File: rtl/zcd_capture_sequencer.sv
// Zero-crossing triggered capture sequencer. After a start it skips cfg_skip
// crossings, then forwards exactly cfg_len (min 1) ADC samples as a burst
// framed by out_last, followed by a one-cycle done pulse.
//   clk, rst              : clock, synchronous active-low reset
//   s_if (slave)          : ADC samples in, captured burst out
//   zcd_pulse             : crossing pulse from zero_crossing_detector
//   cfg_start/cfg_abort   : control pulses
//   cfg_skip/len/timeout  : configuration latched on an accepted start
//   busy, done            : status (ARMED/CAPTURE/DONE, burst complete)
//   timeout_err           : sticky, cleared by the next accepted start
//   out_period            : samples between the last two crossings in ARMED
module zcd_capture_sequencer
  import zcd_capture_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32,
  parameter int SKIP_W = 8,
  parameter int TMO_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  zcd_capture_sequencer_if.slave s_if,
  input  logic                 zcd_pulse,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [SKIP_W-1:0]    cfg_skip,
  input  logic [CNT_W-1:0]     cfg_len,
  input  logic [TMO_W-1:0]     cfg_timeout,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     out_period
);

  zcd_state_e        state, state_nxt;
  logic [SKIP_W-1:0] skip_r, xcnt;
  logic [CNT_W-1:0]  len_r, cap_cnt, cap_nxt;
  logic [TMO_W-1:0]  tmo_r, tmo_cnt;
  logic              seen_r;
  logic              start_acc, trig, tmo_hit, cap_fire, cap_last;
  logic              vld_p1, last_p1;
  logic [DATA_W-1:0] dat_p1;

  function automatic logic [CNT_W-1:0] len_floor1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    trig      = 1'b0;
    tmo_hit   = 1'b0;
    cap_fire  = 1'b0;
    cap_last  = 1'b0;
    cap_nxt   = cap_cnt + CNT_W'(1);
    case (state)
      ST_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          start_acc = 1'b1;
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
        end else if (zcd_pulse && (xcnt == skip_r)) begin
          trig      = 1'b1;
          // cap_cnt is 0 here, so a coincident sample becomes sample 1
          cap_fire  = s_if.in_data_valid;
          cap_last  = cap_fire && (cap_nxt == len_r);
          state_nxt = cap_last ? ST_DONE : ST_CAPTURE;
        end else if ((tmo_r != '0) && (tmo_cnt == tmo_r - TMO_W'(1))) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (cfg_abort) begin
          state_nxt = ST_IDLE;
        end else if (s_if.in_data_valid) begin
          cap_fire = 1'b1;
          cap_last = (cap_nxt == len_r);
          if (cap_last) state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: registered capture outputs and sequencer bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      dat_p1      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      skip_r      <= '0;
      len_r       <= CNT_W'(1);
      tmo_r       <= '0;
      xcnt        <= '0;
      seen_r      <= 1'b0;
      tmo_cnt     <= '0;
      cap_cnt     <= '0;
    end else begin
      vld_p1  <= cap_fire;
      last_p1 <= cap_last;
      if (cap_fire) begin
        dat_p1  <= s_if.in_data;
        cap_cnt <= cap_nxt;
      end
      busy <= (state_nxt != ST_IDLE);
      done <= (state == ST_DONE);
      if (start_acc) begin
        skip_r      <= cfg_skip;
        len_r       <= len_floor1(cfg_len);
        tmo_r       <= cfg_timeout;
        timeout_err <= 1'b0;
        xcnt        <= '0;
        seen_r      <= 1'b0;
        tmo_cnt     <= '0;
        cap_cnt     <= '0;
      end
      if (state == ST_ARMED) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (zcd_pulse) begin
          seen_r <= 1'b1;
          if (!trig) xcnt <= xcnt + SKIP_W'(1);
        end
      end
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  assign s_if.out_data_valid = vld_p1;
  assign s_if.out_last       = last_p1;
  assign s_if.out_data       = dat_p1;

  zcd_period_meter #(.CNT_W(CNT_W)) u_period (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_acc),
    .en      (state == ST_ARMED),
    .smp_vld (s_if.in_data_valid),
    .pulse   (zcd_pulse),
    .seen    (seen_r),
    .period  (out_period)
  );

endmodule

// File: tb/tb_zcd_capture_sequencer.sv
// Directed bench for zcd_capture_sequencer: hand-computed expected bursts,
// periods, timeout and abort/reset behaviour.
module tb_zcd_capture_sequencer;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 32;
  localparam int SKIP_W = 8;
  localparam int TMO_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              zcd_pulse = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_abort = 1'b0;
  logic [SKIP_W-1:0] cfg_skip = '0;
  logic [CNT_W-1:0]  cfg_len = '0;
  logic [TMO_W-1:0]  cfg_timeout = '0;
  logic              busy, done, timeout_err;
  logic [CNT_W-1:0]  out_period;

  zcd_capture_sequencer_if #(.DATA_W(DATA_W)) s_if ();

  zcd_capture_sequencer #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .SKIP_W(SKIP_W), .TMO_W(TMO_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_if        (s_if),
    .zcd_pulse   (zcd_pulse),
    .cfg_start   (cfg_start),
    .cfg_abort   (cfg_abort),
    .cfg_skip    (cfg_skip),
    .cfg_len     (cfg_len),
    .cfg_timeout (cfg_timeout),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .out_period  (out_period)
  );

  // output monitor: cumulative totals, tests work on deltas
  int          cyc_n = 0;
  int          n_vld = 0, n_last = 0, n_done = 0, last_at = 0;
  int          last_cyc = 0, done_cyc = 0;
  logic [15:0] cap_log [0:255];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (s_if.out_data_valid) begin
      cap_log[n_vld[7:0]] <= s_if.out_data;
      n_vld <= n_vld + 1;
    end
    if (s_if.out_last) begin
      n_last   <= n_last + 1;
      last_at  <= n_vld + 1;
      last_cyc <= cyc_n;
    end
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc_n;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int b_vld, b_last, b_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic zp);
    s_if.in_data_valid = v;
    s_if.in_data       = d;
    zcd_pulse          = zp;
    tick();
    s_if.in_data_valid = 1'b0;
    zcd_pulse          = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0);
  endtask

  task automatic start(input int skip, input int len, input int tmo);
    cfg_skip    = SKIP_W'(skip);
    cfg_len     = CNT_W'(len);
    cfg_timeout = TMO_W'(tmo);
    cfg_start   = 1'b1;
    tick();
    cfg_start   = 1'b0;
  endtask

  // nsamp samples, one every gap clocks; pulse on sample i when i%pevery==poff
  task automatic feed(input int nsamp, input int gap, input logic [15:0] base,
                      input int pevery, input int poff);
    logic zp;
    for (int i = 0; i < nsamp; i++) begin
      zp = 1'b0;
      if (pevery > 0) zp = ((i % pevery) == poff);
      cyc(1'b1, base + 16'(i), zp);
      idle(gap - 1);
    end
  endtask

  task automatic snap();
    b_vld  = n_vld;
    b_last = n_last;
    b_done = n_done;
  endtask

  initial begin
    s_if.in_data_valid = 1'b0;
    s_if.in_data       = '0;

    // reset state
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    tick();
    chk("rst_vld",    s_if.out_data_valid, 0);
    chk("rst_data",   s_if.out_data, 0);
    chk("rst_last",   s_if.out_last, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_tmo",    timeout_err, 0);
    chk("rst_period", out_period, 0);

    // start and abort together: abort wins
    cfg_start = 1'b1; cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("startabort_busy", busy, 0);

    // T1: skip=0 len=4, trigger on sample 0x0800
    snap();
    start(0, 4, 0);
    chk("t1_busy", busy, 1);
    feed(8, 6, 16'h07FE, 100, 2);
    idle(3);
    chk("t1_nvld",  n_vld - b_vld, 4);
    chk("t1_first", cap_log[b_vld], 16'h0800);
    chk("t1_4th",   cap_log[b_vld + 3], 16'h0803);
    chk("t1_nlast", n_last - b_last, 1);
    chk("t1_lastat", last_at, b_vld + 4);
    chk("t1_ndone", n_done - b_done, 1);
    chk("t1_donelat", done_cyc - last_cyc, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_hold", s_if.out_data, 16'h0803);

    // T2: skip=2, crossings 20 samples apart, len=3
    snap();
    start(2, 3, 0);
    feed(50, 3, 16'h1000, 20, 0);
    idle(3);
    chk("t2_period", out_period, 20);
    chk("t2_nvld",   n_vld - b_vld, 3);
    chk("t2_first",  cap_log[b_vld], 16'h1028);
    chk("t2_last",   cap_log[b_vld + 2], 16'h102A);
    chk("t2_nlast",  n_last - b_last, 1);
    chk("t2_ndone",  n_done - b_done, 1);

    // T3: timeout=50, no crossings
    snap();
    start(0, 0, 50);
    for (int k = 0; k < 49; k++) cyc((k % 5) == 0, 16'h5000 + 16'(k), 1'b0);
    chk("t3_tmo_early", timeout_err, 0);
    chk("t3_busy_early", busy, 1);
    idle(1);
    chk("t3_tmo", timeout_err, 1);
    chk("t3_busy", busy, 0);
    idle(2);
    chk("t3_nvld",  n_vld - b_vld, 0);
    chk("t3_ndone", n_done - b_done, 0);
    start(0, 4, 0);
    chk("t3_tmo_clr", timeout_err, 0);
    chk("t3_rearm", busy, 1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("t3_abort_armed", busy, 0);

    // T4: abort on the 2nd captured sample, len=10
    snap();
    start(0, 10, 0);
    cyc(1'b1, 16'h4000, 1'b1);
    idle(4);
    cfg_abort = 1'b1;
    cyc(1'b1, 16'h4001, 1'b0);
    cfg_abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_vld",  s_if.out_data_valid, 0);
    chk("t4_last", s_if.out_last, 0);
    feed(4, 4, 16'h4002, 0, 0);
    idle(2);
    chk("t4_nvld",  n_vld - b_vld, 1);
    chk("t4_first", cap_log[b_vld], 16'h4000);
    chk("t4_nlast", n_last - b_last, 0);
    chk("t4_ndone", n_done - b_done, 0);

    // T5: start with len=0 during CAPTURE is ignored; later len=0 gives 1 sample
    snap();
    start(0, 5, 0);
    cyc(1'b1, 16'h2000, 1'b1);
    idle(3);
    cfg_len = '0; cfg_start = 1'b1;
    cyc(1'b1, 16'h2001, 1'b0);
    cfg_start = 1'b0;
    idle(3);
    feed(6, 4, 16'h2002, 0, 0);
    idle(3);
    chk("t5_nvld",  n_vld - b_vld, 5);
    chk("t5_last",  cap_log[b_vld + 4], 16'h2004);
    chk("t5_lastat", last_at, b_vld + 5);
    chk("t5_ndone", n_done - b_done, 1);
    snap();
    start(0, 0, 0);
    feed(3, 4, 16'h3000, 3, 0);
    idle(3);
    chk("t5b_nvld",  n_vld - b_vld, 1);
    chk("t5b_data",  cap_log[b_vld], 16'h3000);
    chk("t5b_nlast", n_last - b_last, 1);
    chk("t5b_ndone", n_done - b_done, 1);

    // T6: reset for one cycle mid-CAPTURE
    snap();
    start(0, 6, 0);
    cyc(1'b1, 16'h6000, 1'b1);
    idle(3);
    cyc(1'b1, 16'h6001, 1'b0);
    idle(3);
    rst = 1'b0;
    cyc(1'b1, 16'h6002, 1'b0);
    rst = 1'b1;
    chk("t6_vld",    s_if.out_data_valid, 0);
    chk("t6_data",   s_if.out_data, 0);
    chk("t6_last",   s_if.out_last, 0);
    chk("t6_busy",   busy, 0);
    chk("t6_done",   done, 0);
    chk("t6_period", out_period, 0);
    idle(2);
    chk("t6_nvld",  n_vld - b_vld, 2);
    chk("t6_nlast", n_last - b_last, 0);
    snap();
    start(0, 2, 0);
    feed(4, 4, 16'h7000, 4, 0);
    idle(3);
    chk("t6b_nvld",  n_vld - b_vld, 2);
    chk("t6b_first", cap_log[b_vld], 16'h7000);
    chk("t6b_last",  cap_log[b_vld + 1], 16'h7001);
    chk("t6b_nlast", n_last - b_last, 1);
    chk("t6b_ndone", n_done - b_done, 1);
    chk("t6b_busy",  busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
